// File: rtl/deltasigma_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma modulator.
package deltasigma_pkg;

  localparam int ORDER_FIRST  = 1;
  localparam int ORDER_SECOND = 2;

  // Channel index width; a single channel still gets a 1-bit select.
  function automatic int CHW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // First-order reset phase: spreads channel carries evenly over one period.
  function automatic int offset(input int k, input int ch, input int bits);
    return ((k * (1 << bits)) / ch) % (1 << bits);
  endfunction

endpackage

// File: rtl/deltasigma_chan.sv
// One modulator channel: active code register plus first- or second-order loop.
module deltasigma_chan
  import deltasigma_pkg::*;
#(
  parameter int BITS     = 5,
  parameter int CH       = 4,
  parameter int ORDER    = 1,
  parameter int CHAN_IDX = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic            out
);

  logic [BITS-1:0] active_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the step below must see the old active_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      active_q <= '0;
    else if (load) active_q <= load_val;
  end

  if (ORDER == ORDER_FIRST) begin : g_order1
    logic [BITS-1:0] acc_q, acc_d;
    logic            out_q, out_d;
    logic [BITS:0]   sum;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, active_q};
      acc_d = acc_q;
      out_d = out_q;
      if (step) begin
        acc_d = sum[BITS-1:0];
        out_d = sum[BITS];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q <= BITS'(offset(CHAN_IDX, CH, BITS));
        out_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        out_q <= out_d;
      end
    end

    assign out = out_q;
  end else if (ORDER == ORDER_SECOND) begin : g_order2
    logic signed [BITS+1:0] i1_q, i1_d;
    logic signed [BITS+3:0] i2_q, i2_d;
    logic                   out_q, out_d;
    int                     fb;
    int                     i1_sum;

    // Feedback is full scale whenever the outer integrator is non-negative.
    always_comb begin
      fb     = (i2_q >= 0) ? (1 << BITS) : 0;
      i1_sum = sat_add(int'(i1_q) + int'(active_q), -fb, BITS + 2);
      i1_d   = i1_q;
      i2_d   = i2_q;
      out_d  = out_q;
      if (step) begin
        i1_d  = (BITS+2)'(i1_sum);
        i2_d  = (BITS+4)'(sat_add(int'(i2_q), i1_sum - fb, BITS + 4));
        out_d = (i2_q >= 0);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        i1_q  <= '0;
        i2_q  <= '0;
        out_q <= 1'b0;
      end else begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        out_q <= out_d;
      end
    end

    assign out = out_q;
  end else begin : g_bad_order
    $error("deltasigma_chan: ORDER must be 1 or 2");
  end

endmodule

// File: rtl/deltasigma_mc.sv
// Multi-channel delta-sigma modulator: shadow codes, synchronous commit, shared step.
module deltasigma_mc
  import deltasigma_pkg::*;
#(
  parameter int BITS  = 5,
  parameter int CH    = 4,
  parameter int ORDER = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITS-1:0]      data_in,
  input  logic [CHW(CH)-1:0]   data_in_ch,
  input  logic                 data_in_en,
  input  logic                 commit,
  input  logic                 next,
  output logic [CH-1:0]        out
);

  localparam int CW = CHW(CH);

  if (CH < 1 || CH > 16) begin : g_bad_ch
    $error("deltasigma_mc: CH must be in 1..16");
  end

  logic [BITS-1:0] shadow_q [CH];
  logic [BITS-1:0] load_val [CH];
  logic [CH-1:0]   wr_hit;

  // Out-of-range channel selects match no k and are dropped.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      wr_hit[k]   = data_in_en && (data_in_ch == CW'(k));
      load_val[k] = wr_hit[k] ? data_in : shadow_q[k];
    end
  end

  // NOTE: the shadow array is small and must read as zero after reset, so it
  // is a reset register bank rather than an un-reset RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) shadow_q[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (wr_hit[k]) shadow_q[k] <= data_in;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_chan
    deltasigma_chan #(
      .BITS    (BITS),
      .CH      (CH),
      .ORDER   (ORDER),
      .CHAN_IDX(k)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .step    (next),
      .load    (commit),
      .load_val(load_val[k]),
      .out     (out[k])
    );
  end

endmodule

// File: tb/tb_deltasigma_mc.sv
// Self-checking bench: ORDER=1 and ORDER=2 instances against a behavioural model.
module tb_deltasigma_mc;

  localparam int BITS = 5;
  localparam int CH   = 4;
  localparam int M    = 1 << BITS;

  logic            clk;
  logic            rst;
  logic [BITS-1:0] data_in;
  logic [1:0]      data_in_ch;
  logic            data_in_en;
  logic            commit;
  logic            next;
  logic [CH-1:0]   o1;
  logic [CH-1:0]   o2;

  deltasigma_mc #(.BITS(BITS), .CH(CH), .ORDER(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_ch(data_in_ch),
    .data_in_en(data_in_en), .commit(commit), .next(next), .out(o1)
  );

  deltasigma_mc #(.BITS(BITS), .CH(CH), .ORDER(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_ch(data_in_ch),
    .data_in_en(data_in_en), .commit(commit), .next(next), .out(o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model. First order is tracked as an unbounded running total of
  // codes: an output one is emitted whenever that total crosses a multiple of M.
  int            sh [CH];
  int            act [CH];
  longint        tot [CH];
  int            i1 [CH];
  int            i2 [CH];
  logic [CH-1:0] m_o1;
  logic [CH-1:0] m_o2;

  function automatic int clamp(input int v, input int lim);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      sh[k]  = 0;
      act[k] = 0;
      tot[k] = (k * M) / CH;
      i1[k]  = 0;
      i2[k]  = 0;
    end
    m_o1 = '0;
    m_o2 = '0;
  endtask

  task automatic model_edge(input bit en, input int ch, input int din, input bit cm, input bit nx);
    int fb;
    if (nx) begin
      for (int k = 0; k < CH; k++) begin
        m_o1[k] = (((tot[k] + act[k]) / M) != (tot[k] / M));
        tot[k]  = tot[k] + act[k];
        fb      = (i2[k] >= 0) ? M : 0;
        m_o2[k] = (i2[k] >= 0);
        i1[k]   = clamp(i1[k] + act[k] - fb, 2 * M);
        i2[k]   = clamp(i2[k] + i1[k] - fb, 8 * M);
      end
    end
    if (cm) begin
      for (int k = 0; k < CH; k++) act[k] = sh[k];
      if (en && ch < CH) act[ch] = din;
    end
    if (en && ch < CH) sh[ch] = din;
  endtask

  task automatic cycle(input bit en, input int ch, input int din, input bit cm, input bit nx);
    @(negedge clk);
    data_in_en = en;
    data_in_ch = 2'(ch);
    data_in    = BITS'(din);
    commit     = cm;
    next       = nx;
    @(posedge clk);
    model_edge(en, ch, din, cm, nx);
    #1;
    check("out_order1_vs_model", 32'(o1), 32'(m_o1));
    check("out_order2_vs_model", 32'(o2), 32'(m_o2));
    data_in_en = 1'b0;
    commit     = 1'b0;
    next       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_out1", 32'(o1), 32'd0);
    check("reset_out2", 32'(o2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit       en;
    int       ch;
    int       din;
    bit       cm;
    bit       nx;
    logic [3:0] e1;
    logic [3:0] e2;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int c0, c1, c2, c3;
    logic [CH-1:0] s1, s2;

    rst = 1'b0; data_in = '0; data_in_ch = '0; data_in_en = 1'b0; commit = 1'b0; next = 1'b0;
    model_reset();

    // Reset-offset table: code 16 everywhere, ch3 written with a bypassed commit.
    tbl[0] = '{1'b1, 0, 16, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[1] = '{1'b1, 1, 16, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[2] = '{1'b1, 2, 16, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[3] = '{1'b1, 3, 16, 1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[4] = '{1'b0, 0,  0, 1'b0, 1'b1, 4'b1100, 4'b1111};
    tbl[5] = '{1'b0, 0,  0, 1'b0, 1'b1, 4'b0011, 4'b0000};
    tbl[6] = '{1'b0, 0,  0, 1'b0, 1'b1, 4'b1100, 4'b0000};
    tbl[7] = '{1'b0, 0,  0, 1'b0, 1'b1, 4'b0011, 4'b0000};
    tbl[8] = '{1'b0, 0,  0, 1'b0, 1'b1, 4'b1100, 4'b1111};

    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].en, tbl[i].ch, tbl[i].din, tbl[i].cm, tbl[i].nx);
      check($sformatf("tbl%0d_out1", i), 32'(o1), 32'(tbl[i].e1));
      check($sformatf("tbl%0d_out2", i), 32'(o2), 32'(tbl[i].e2));
    end

    // Code 7 on ch0 only.
    do_reset();
    cycle(1, 0, 7, 1, 0);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, 0, 0, 1);
      c0 += int'(o1[0]);
      c1 += int'(o1[1]) + int'(o1[2]) + int'(o1[3]);
    end
    check("code7_ch0_ones", c0, 7);
    check("code7_idle_ch_ones", c1, 0);

    // Extremes: 0 on ch1, 31 on ch2.
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 2, 31, 1, 0);
    c1 = 0; c2 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, 0, 0, 1);
      c1 += int'(o1[1]);
      c2 += int'(o1[2]);
    end
    check("code0_ch1_ones", c1, 0);
    check("code31_ch2_ones", c2, 31);

    // Commit ordering.
    do_reset();
    cycle(1, 0, 31, 0, 0);
    c0 = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 1);
      c0 += int'(o1[0]);
    end
    check("uncommitted_ch0_ones", c0, 0);
    cycle(0, 0, 0, 1, 1);
    check("commit_step_uses_old", 32'(o1[0]), 32'd0);
    c0 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, 0, 0, 1);
      c0 += int'(o1[0]);
    end
    check("after_commit_ones", c0, 31);

    // Simultaneous write, commit and step on one edge.
    do_reset();
    cycle(1, 1, 5, 1, 0);
    cycle(1, 1, 20, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);

    // Second-order density.
    do_reset();
    cycle(1, 0, 16, 1, 0);
    c0 = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(0, 0, 0, 0, 1);
      c0 += int'(o2[0]);
    end
    check("order2_code16_range", 32'(c0 >= 30 && c0 <= 34), 32'd1);
    do_reset();
    cycle(1, 0, 8, 1, 0);
    c0 = 0;
    for (int i = 0; i < 128; i++) begin
      cycle(0, 0, 0, 0, 1);
      c0 += int'(o2[0]);
    end
    check("order2_code8_range", 32'(c0 >= 30 && c0 <= 34), 32'd1);

    // Mid-stream asynchronous reset.
    do_reset();
    for (int k = 0; k < CH; k++) cycle(1, k, 16, (k == CH - 1), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    check("pre_reset_out1_active", 32'(o1), 32'(4'b1100));
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_reset_out1", 32'(o1), 32'd0);
    check("async_reset_out2", 32'(o2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c0 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, 0, 0, 1);
      c0 += int'(o1[0]) + int'(o1[1]) + int'(o1[2]) + int'(o1[3]);
    end
    check("post_reset_out1_ones", c0, 0);

    // Hold with next low.
    cycle(1, 2, 9, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);
    s1 = o1;
    s2 = o2;
    c3 = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, i % CH, i, (i % 3) == 0, 0);
      c3 += int'(o1 != s1) + int'(o2 != s2);
    end
    check("hold_out_changes", c3, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, CH - 1)),
            int'($urandom_range(0, M - 1)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deltasigma_mc.md
# deltasigma_mc

Multi-channel delta-sigma modulator, the parametrised successor to the single-channel `deltasigma`. Each of `CH` channels converts a `BITS`-bit unsigned code into a 1-bit density stream. Modulator order is selectable at elaboration: first-order accumulator or second-order loop. A double-buffered load path lets all channels switch to new codes on the same step. It drives the PWM/DAC output pins, stepped by a shared `next` strobe.

## Interface
- `BITS`, 5: code width; output density = code / 2^BITS.
- `CH`, 4: channel count, 1..16.
- `ORDER`, 1: modulator order, 1 or 2. Any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low; all state clears on assertion.
- `data_in` in BITS: code to write.
- `data_in_ch` in $clog2(CH) (min 1): target channel for the write.
- `data_in_en` in 1: writes `data_in` into the shadow register of `data_in_ch`.
- `commit` in 1: copies every shadow register into its active register.
- `next` in 1: modulator step enable, one step per cycle while high.
- `out` out CH: registered bitstreams, one bit per channel.

## Operation
- Shadow write: on an edge with `data_in_en`=1, `shadow[data_in_ch]` <= `data_in`. A `data_in_ch` >= CH is ignored.
- Commit: on an edge with `commit`=1, `active[k]` <= `shadow[k]` for all k.
  - Same-edge `data_in_en` to channel j is bypassed, so `active[j]` gets the new `data_in`.
- Step rules, ORDER=1, applied when `next`=1:
  - sum = `acc[k]` + `active[k]`, width BITS+1.
  - `out[k]` <= sum[BITS].
  - `acc[k]` <= sum[BITS-1:0].
- ORDER=1 reset offset: `acc[k]` resets to (k·2^BITS/CH) mod 2^BITS, which staggers edges across channels. `out` resets to 0.
- Step rules, ORDER=2, applied when `next`=1:
  - F = 2^BITS if `i2[k]` >= 0, else 0.
  - `out[k]` <= (`i2[k]` >= 0).
  - `i1'` = sat(`i1` + `active` − F).
  - `i2'` = sat(`i2` + `i1'` − F).
- ORDER=2 widths: `i1` signed BITS+2, `i2` signed BITS+4. Saturating add clamps to the signed range, with no wrap.
- ORDER=2 reset: `i1`=`i2`=0; `out` resets to 0.
- `next`=0: accumulators and `out` hold. Shadow writes and commits still take effect.
- Reset values: shadow=0, active=0, and `out`=0 on all channels.

## Timing
- Mid-operation reset: asserting `rst` clears everything asynchronously, and `out` goes to 0 immediately.
  - After release, the first step occurs on the first rising edge with `next`=1.
- Commit/step ordering: on a step edge the modulator uses the `active` value held before that edge.
  - A commit on edge t therefore affects steps from edge t+1.
- Minimum latency from `data_in_en` to the new code influencing `out` is 2 edges:
  - write plus commit on edge t;
  - first step using it on edge t+1, visible on `out` after edge t+1.
- Long-run density: ORDER=1 gives exactly `active`/2^BITS ones over any 2^BITS consecutive steps. ORDER=2 converges to the same mean.
- Simultaneous `data_in_en`, `commit` and `next` on one edge:
  - the step uses the old active value;
  - active takes the bypassed value;
  - shadow stores `data_in`.

## Structure
- Package `deltasigma_pkg`:
  - `CHW(CH)` index-width function, giving at least 1 bit;
  - ORDER enum or constants;
  - saturating signed-add function;
  - the ORDER=1 offset function `offset(k, CH, BITS)`.
- Sub-module `deltasigma_chan`, instanced CH times via generate:
  - holds one channel's `active` and accumulator state;
  - takes `step`, `load` and `load_val` inputs;
  - takes `CHAN_IDX` as a parameter for the reset offset.
- Top level holds the shadow array, write decode and commit bypass.

## Test plan
- BITS=5, CH=4, ORDER=1: write 7 to ch0, commit, hold `next` 32 cycles -> exactly 7 ones on `out[0]`, and channels 1–3 remain all-zero.
- Write 0 to ch1 and 31 to ch2, commit, 32 steps -> `out[1]` all 0 and `out[2]` has 31 ones.
- Reset offset: write 16 to all channels, commit, step:
  - ch0 gives out 0,1,0,1…;
  - ch2 gives out 1,0,1,0… (first one at step 1);
  - ch1 and ch3 have a first one at step 2 and step 1 respectively.
- Commit ordering:
  - write 31 to ch0 with no commit, 10 steps -> `out[0]` stays 0;
  - raise `commit` together with `next` -> that step is 0 and the following steps produce ones.
- ORDER=2, BITS=5: code 16 for 64 steps -> 30..34 ones. Code 8 for 128 steps -> 30..34 ones. No integrator hits its saturation limit.
- Mid-stream reset:
  - assert `rst` low between edges while running -> `out` is 0 before the next edge;
  - after release with no write, 32 steps -> `out` all 0 (active cleared);
  - `next` held low for 20 cycles -> `out` constant.
